// File: rtl/noc_pkg.sv
// Shared NoC definitions: default coordinate widths, node id, direction codes,
// the tdest/tid packing helper, and the network-interface transmit FSM states.
// Pure declarations; no logic, no latency, no flow control.
package noc_pkg;

  localparam int NOC_DX_W = 2;
  localparam int NOC_DY_W = 2;

  typedef struct packed {
    logic [NOC_DY_W-1:0] y;
    logic [NOC_DX_W-1:0] x;
  } node_id_t;

  // Router port directions; P is the local injection/ejection port.
  typedef enum logic [2:0] {
    DIR_P = 3'd0,
    DIR_E = 3'd1,
    DIR_W = 3'd2,
    DIR_N = 3'd3,
    DIR_S = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_DROP = 2'd2
  } tx_state_e;

  // Packs a coordinate pair as {y,x}, x occupying the low x_w bits.
  // Callers truncate the result to their tdest/tid width; upper bits are zero.
  function automatic logic [31:0] pack_xy(input logic [15:0] y,
                                          input logic [15:0] x,
                                          input int          x_w);
    pack_xy = ({16'd0, y} << x_w) | {16'd0, x};
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-stream bundle between a network interface and a mesh node port.
// Wires only; no latency.
// Master drives tvalid/payload, slave drives tready.
interface axi4_stream_if #(
  parameter int TDATA_W = 32,
  parameter int TDEST_W = 4,
  parameter int TID_W   = 4,
  parameter int TUSER_W = 4
) ();
  logic               tvalid;
  logic               tready;
  logic [TDATA_W-1:0] tdata;
  logic [TDEST_W-1:0] tdest;
  logic [TID_W-1:0]   tid;
  logic [TUSER_W-1:0] tuser;
  logic               tlast;

  modport Master (output tvalid, tdata, tdest, tid, tuser, tlast, input tready);
  modport Slave  (input tvalid, tdata, tdest, tid, tuser, tlast, output tready);
endinterface

// File: rtl/noc_skid_buf.sv
// Two-entry registered buffer over one packed beat word.
// Latency: a beat written in cycle N is presented on out_* in cycle N+1.
// Backpressure: full is a pure flop decode, so the writer's ready never sees out_rdy combinationally.
// Ports: clk, rst_n (async active-low); in_vld/in_dat write side (ignored while full);
//        full; out_vld/out_rdy/out_dat read side, out_dat held stable while out_vld & !out_rdy.
module noc_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         full,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign full    = (cnt_q == 2'd2);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = mem_q[rd_ptr_q];

  always_comb begin
    push     = in_vld && !full;
    pop      = out_vld && out_rdy;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: it is only observed while cnt_q says it is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/noc_ni_tx.sv
// Network-interface transmitter: frames command + payload into AXI4-stream packets for the local mesh port.
// Latency: payload beat accepted in cycle N appears on noc_req_o in cycle N+1; one idle command cycle between packets.
// Backpressure: dat_ready follows skid-buffer occupancy only (registered), never tready directly.
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_dx/cmd_dy/cmd_len command;
//        dat_valid/dat_ready/dat_data payload; err_o sticky out-of-mesh flag, err_clr clears it;
//        noc_req_o packet stream (tdest={dy,dx}, tid={CUR_Y,CUR_X}, tuser=sequence, tlast=final beat).
// Build option NOC_NI_TX_PERF_EN adds pkt_cnt_o (tlast handshakes) and stall_cnt_o (tvalid & !tready cycles).
module noc_ni_tx
  import noc_pkg::*;
#(
  parameter int MSH_W   = 4,
  parameter int MSH_H   = 4,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0,
  parameter int DX_W    = NOC_DX_W,
  parameter int DY_W    = NOC_DY_W,
  parameter int LEN_W   = 8,
  parameter int SEQ_W   = 4,
  parameter int TDATA_W = 32,
  parameter int TDEST_W = 4,
  parameter int TID_W   = 4,
  parameter int TUSER_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DX_W-1:0]    cmd_dx,
  input  logic [DY_W-1:0]    cmd_dy,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               dat_valid,
  output logic               dat_ready,
  input  logic [TDATA_W-1:0] dat_data,
  output logic               err_o,
  input  logic               err_clr,
`ifdef NOC_NI_TX_PERF_EN
  output logic [31:0]        pkt_cnt_o,
  output logic [31:0]        stall_cnt_o,
`endif
  axi4_stream_if.Master      noc_req_o
);

  if (TDEST_W < DX_W + DY_W) begin : g_chk_tdest
    $error("noc_ni_tx: TDEST_W too narrow for {dy,dx}");
  end
  if (TID_W < DX_W + DY_W) begin : g_chk_tid
    $error("noc_ni_tx: TID_W too narrow for {CUR_Y,CUR_X}");
  end
  if (TUSER_W < SEQ_W) begin : g_chk_tuser
    $error("noc_ni_tx: TUSER_W too narrow for the sequence number");
  end

  typedef struct packed {
    logic [TDATA_W-1:0] tdata;
    logic [TDEST_W-1:0] tdest;
    logic [TID_W-1:0]   tid;
    logic [TUSER_W-1:0] tuser;
    logic               tlast;
  } beat_t;

  tx_state_e          state_q, state_d;
  logic [DX_W-1:0]    dx_q, dx_d;
  logic [DY_W-1:0]    dy_q, dy_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               err_q, err_d;
  // Holds cmd_ready low through reset and releases it on the first clock after.
  logic               live_q, live_d;

  logic               err_set;
  logic               in_mesh;
  logic               last_beat;
  logic               buf_full;
  logic               push_vld;
  beat_t              push_beat;
  logic               out_vld;
  beat_t              out_beat;

  assign in_mesh   = (32'(cmd_dx) < MSH_W) && (32'(cmd_dy) < MSH_H);
  assign last_beat = (beat_cnt_q == len_q);

  always_comb begin
    state_d    = state_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    seq_d      = seq_q;
    live_d     = 1'b1;
    err_set    = 1'b0;
    cmd_ready  = 1'b0;
    dat_ready  = 1'b0;
    push_vld   = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        cmd_ready = live_q;
        if (cmd_valid && live_q) begin
          dx_d       = cmd_dx;
          dy_d       = cmd_dy;
          len_d      = cmd_len;
          beat_cnt_d = '0;
          if (in_mesh) begin
            state_d = TX_SEND;
          end else begin
            // Flag at acceptance; the payload is still drained so the source never stalls.
            state_d = TX_DROP;
            err_set = 1'b1;
          end
        end
      end
      TX_SEND: begin
        dat_ready = !buf_full;
        if (dat_valid && !buf_full) begin
          push_vld = 1'b1;
          if (last_beat) begin
            seq_d   = seq_q + 1'b1;
            state_d = TX_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      TX_DROP: begin
        dat_ready = 1'b1;
        if (dat_valid) begin
          if (last_beat) begin
            state_d = TX_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // A new error outranks a clear in the same cycle.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_comb begin
    push_beat.tdata = dat_data;
    push_beat.tdest = TDEST_W'(pack_xy(16'(dy_q), 16'(dx_q), DX_W));
    push_beat.tid   = TID_W'(pack_xy(16'(CUR_Y), 16'(CUR_X), DX_W));
    push_beat.tuser = TUSER_W'(seq_q);
    push_beat.tlast = last_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      dx_q       <= '0;
      dy_q       <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      seq_q      <= '0;
      err_q      <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
      live_q     <= live_d;
    end
  end

  noc_skid_buf #(.W($bits(beat_t))) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (push_vld),
    .in_dat  (push_beat),
    .full    (buf_full),
    .out_vld (out_vld),
    .out_rdy (noc_req_o.tready),
    .out_dat (out_beat)
  );

  assign noc_req_o.tvalid = out_vld;
  assign noc_req_o.tdata  = out_beat.tdata;
  assign noc_req_o.tdest  = out_beat.tdest;
  assign noc_req_o.tid    = out_beat.tid;
  assign noc_req_o.tuser  = out_beat.tuser;
  assign noc_req_o.tlast  = out_beat.tlast;
  assign err_o            = err_q;

`ifdef NOC_NI_TX_PERF_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_vld && noc_req_o.tready && out_beat.tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
    if (out_vld && !noc_req_o.tready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
